// File: rtl/fir_band_scheduler_pkg.sv
// Shared widths, sequencing limits and state encoding for the five-band FIR scheduler.
// The accumulate helper keeps the 18-bit product / 24-bit accumulator arithmetic in one place.
package fir_band_scheduler_pkg;

  localparam int NTAPS   = 61;
  localparam int NBANDS  = 5;
  localparam int SAMP_W  = 8;
  localparam int COEF_W  = 10;
  localparam int PROD_W  = 18;
  localparam int ACC_W   = 24;
  localparam int IDX_W   = 6;
  localparam int BAND_W  = 3;

  localparam logic [IDX_W-1:0]  LAST_TAP  = IDX_W'(NTAPS - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NBANDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  // Full-precision product sign-extended into the accumulator; 61 taps of 8x10 cannot overflow 24 bits.
  function automatic logic signed [ACC_W-1:0] mac_step(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [COEF_W-1:0] c,
    input logic signed [SAMP_W-1:0] s
  );
    logic signed [PROD_W-1:0] p;
    p = c * s;
    return acc + {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/fir_band_scheduler_sample_ring.sv
// 64x8 sample history: one synchronous write port, one combinational read port.
// Cleared by reset so a restarted stream sees an all-zero past.
module fir_sample_ring
  import fir_band_scheduler_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [SAMP_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [SAMP_W-1:0] rdata
);

  logic [SAMP_W-1:0] mem_r [64];

  // History storage with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fir_band_scheduler.sv
// Time-multiplexed FIR controller: one shared MAC walks 61 taps for each of five bands per sample,
// addressing an external coefficient ROM bank and a 64-entry circular sample history.
module fir_band_scheduler
  import fir_band_scheduler_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ready,
  input  logic signed [SAMP_W-1:0] x_in,
  output logic [IDX_W-1:0]         coeff_index,
  output logic [BAND_W-1:0]        band_sel,
  input  logic signed [COEF_W-1:0] coeff,
  output logic signed [ACC_W-1:0]  y_out,
  output logic [BAND_W-1:0]        y_band,
  output logic                     y_valid,
  output logic                     done,
  output logic                     busy,
  output logic                     overrun
);

  state_t                    state_r;
  logic [IDX_W-1:0]          offset_r;
  logic [IDX_W-1:0]          k_r;
  logic [BAND_W-1:0]         band_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [ACC_W-1:0]   y_out_r;
  logic [BAND_W-1:0]         y_band_r;
  logic                      y_valid_r;
  logic                      done_r;
  logic                      busy_r;
  logic                      overrun_r;

  logic                      accept_s;
  logic [IDX_W-1:0]          waddr_s;
  logic [IDX_W-1:0]          raddr_s;
  logic [SAMP_W-1:0]         rdata_s;

  assign accept_s = (state_r == ST_IDLE) && ready;
  assign waddr_s  = offset_r + 6'd1;
  // Newest sample sits at offset; tap k reaches k samples into the past, wrapping mod 64.
  assign raddr_s  = offset_r - k_r;

  fir_sample_ring u_ring (
    .clock (clock),
    .reset (reset),
    .we    (accept_s),
    .waddr (waddr_s),
    .wdata (x_in),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Sequencer: accept sample, MAC 61 taps per band, dump each band result, return to idle after band 4.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      offset_r  <= 6'd0;
      k_r       <= 6'd0;
      band_r    <= 3'd0;
      acc_r     <= 24'sd0;
      y_out_r   <= 24'sd0;
      y_band_r  <= 3'd0;
      y_valid_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      y_valid_r <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= ready && (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (ready) begin
            offset_r <= offset_r + 6'd1;
            k_r      <= 6'd0;
            band_r   <= 3'd0;
            acc_r    <= 24'sd0;
            busy_r   <= 1'b1;
            state_r  <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_r <= mac_step(acc_r, coeff, $signed(rdata_s));
          // k returns to 0 on the last tap so coeff_index already reads 0 during DUMP.
          if (k_r == LAST_TAP) begin
            k_r     <= 6'd0;
            state_r <= ST_DUMP;
          end else begin
            k_r <= k_r + 6'd1;
          end
        end
        ST_DUMP: begin
          y_out_r   <= acc_r;
          y_band_r  <= band_r;
          y_valid_r <= 1'b1;
          acc_r     <= 24'sd0;
          k_r       <= 6'd0;
          if (band_r == LAST_BAND) begin
            done_r  <= 1'b1;
            band_r  <= 3'd0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            band_r  <= band_r + 3'd1;
            state_r <= ST_MAC;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign coeff_index = k_r;
  assign band_sel    = band_r;
  assign y_out       = y_out_r;
  assign y_band      = y_band_r;
  assign y_valid     = y_valid_r;
  assign done        = done_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Scoreboard bench for fir_band_scheduler: a direct-form FIR reference over the full sample history
// predicts each band result and its arrival cycle; a negedge monitor pops and compares.
module tb_fir_band_scheduler;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ready = 1'b0;
  logic signed [7:0] x_in  = 8'sd0;
  logic [5:0]        coeff_index;
  logic [2:0]        band_sel;
  logic signed [9:0] coeff;
  logic signed [23:0] y_out;
  logic [2:0]        y_band;
  logic              y_valid;
  logic              done;
  logic              busy;
  logic              overrun;

  typedef struct {
    int band;
    int val;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   hist[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   last_t = -100000;
  int   ov_cyc = -1;

  fir_band_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .ready       (ready),
    .x_in        (x_in),
    .coeff_index (coeff_index),
    .band_sel    (band_sel),
    .coeff       (coeff),
    .y_out       (y_out),
    .y_band      (y_band),
    .y_valid     (y_valid),
    .done        (done),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Coefficient ROM bank model; a few taps pinned to known values for hand-checkable impulse results.
  function automatic int coef_i(input int b, input int k);
    if (b == 0 && k == 0) return 84;
    if (b == 0 && k == 1) return -9;
    if ((b == 1 || b == 2) && k == 0) return 0;
    if (b == 4 && k == 30) return 274;
    if (b == 3 && k == 30) return 136;
    return ((b * 37 + k * 53 + b * k * 11) % 201) - 100;
  endfunction

  assign coeff = 10'(coef_i(int'(band_sel), int'(coeff_index)));

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called one step after a posedge; drives ready for exactly one cycle.
  task automatic send(input int x);
    int t;
    int acc;
    int n;
    t = cyc;
    ready = 1'b1;
    x_in = 8'(x);
    if (t > last_t + 310) begin
      hist.push_back(x);
      n = hist.size();
      for (int b = 0; b < 5; b++) begin
        acc = 0;
        for (int k = 0; k < 61; k++) begin
          if (k < n) acc += coef_i(b, k) * hist[n - 1 - k];
        end
        sbq.push_back('{band: b, val: acc, cyc: t + 63 + 62 * b});
      end
      last_t = t;
    end else begin
      ov_cyc = t + 1;
    end
    @(posedge clock);
    #1 ready = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    hist.delete();
    last_t = -100000;
    ov_cyc = -1;
    #1;
    check("reset y_out", y_out, 0);
    check("reset y_band", y_band, 0);
    check("reset y_valid", y_valid, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor: per-cycle busy/overrun/done expectations and scoreboard pops on y_valid.
  always @(negedge clock) begin
    if (!reset) begin
      logic exp_done;
      exp_t e;
      exp_done = 1'b0;
      check("busy", busy, (cyc >= last_t + 1) && (cyc <= last_t + 310));
      check("overrun", overrun, cyc == ov_cyc);
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        check("missing y_valid", e.cyc, cyc);
      end
      if (y_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected y_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("y_valid cycle", cyc, e.cyc);
          check("y_band", y_band, e.band);
          check("y_out", y_out, e.val);
          exp_done = (e.band == 4);
        end
      end
      check("done", done, exp_done);
    end
  end

  initial begin
    int off;
    #1;
    do_reset();
    idle(2);

    // Impulse 127: band0 10668 then -1143, bands 1,2 zero on first sample.
    send(127);  idle(310);
    send(0);    idle(310);

    // Clean history, impulse -128 then 30 zeros: 31st sample band4 -35072, band3 -17408.
    idle(5);
    do_reset();
    send(-128); idle(310);
    for (int i = 0; i < 30; i++) begin
      send(0); idle(310);
    end

    // Second ready at T+100 is discarded and flagged the following cycle.
    send(55);   idle(99);
    send(-77);  idle(210);
    send(3);    idle(310);

    // Reset at T+150 abandons the sample; restart sees zeroed history.
    send(100);  idle(149);
    do_reset();
    idle(200);
    send(127);  idle(310);

    // Random stream wraps the ring offset several times, with occasional overruns and idle gaps.
    for (int i = 0; i < 200; i++) begin
      send($urandom_range(0, 255) - 128);
      if ($urandom_range(0, 3) == 0) begin
        off = $urandom_range(1, 309);
        idle(off - 1);
        send($urandom_range(0, 255) - 128);
        idle(310 - off);
      end else begin
        idle(310 + $urandom_range(0, 2));
      end
    end
    send(127);  idle(310);

    idle(20);
    check("scoreboard drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
